// File: rtl/miriscv_pkg.sv
// Shared types and constants for the miriscv data-port arbiter.
package miriscv_pkg;

  localparam int DATA_W      = 32;
  localparam int BE_W        = 4;
  localparam int MASTER_CORE = 0;
  localparam int MASTER_EXT  = 1;

  typedef enum logic {
    PRIO0 = 1'b0,
    PRIO1 = 1'b1
  } arb_state_e;

endpackage

// File: rtl/miriscv_data_arb_if.sv
// Bus bundle for both requesting masters and the shared RAM data port.
interface miriscv_data_arb_if;
  import miriscv_pkg::*;

  logic              m0_req_i;
  logic              m0_we_i;
  logic [BE_W-1:0]   m0_be_i;
  logic [DATA_W-1:0] m0_addr_i;
  logic [DATA_W-1:0] m0_wdata_i;
  logic              m0_gnt_o;
  logic              m0_rvalid_o;
  logic [DATA_W-1:0] m0_rdata_o;
  logic              m0_err_o;

  logic              m1_req_i;
  logic              m1_we_i;
  logic [BE_W-1:0]   m1_be_i;
  logic [DATA_W-1:0] m1_addr_i;
  logic [DATA_W-1:0] m1_wdata_i;
  logic              m1_gnt_o;
  logic              m1_rvalid_o;
  logic [DATA_W-1:0] m1_rdata_o;
  logic              m1_err_o;

  logic              ram_req_o;
  logic              ram_we_o;
  logic [BE_W-1:0]   ram_be_o;
  logic [DATA_W-1:0] ram_addr_o;
  logic [DATA_W-1:0] ram_wdata_o;
  logic [DATA_W-1:0] ram_rdata_i;

  modport slave (
    input  m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i,
    output m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
    input  m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i,
    output m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
    output ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o,
    input  ram_rdata_i
  );

  modport master (
    output m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i,
    input  m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
    output m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i,
    input  m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
    input  ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o,
    output ram_rdata_i
  );

endinterface

// File: rtl/miriscv_arb_prio.sv
// Two-master grant FSM. MIRISCV_DATA_ARB_RR_EN selects round-robin; otherwise
// fixed priority to master 0 with a starvation override for master 1.
module miriscv_arb_prio
  import miriscv_pkg::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  arb_state_e state_q, state_d;
  logic       ext_wins;

  // Contention resolves to whichever master the FSM currently favours.
  assign ext_wins           = (state_q == PRIO1);
  assign gnt_o[MASTER_CORE] = rst_n_i & req_i[MASTER_CORE] & (~req_i[MASTER_EXT] | ~ext_wins);
  assign gnt_o[MASTER_EXT]  = rst_n_i & req_i[MASTER_EXT] & (~req_i[MASTER_CORE] | ext_wins);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= PRIO0;
    else          state_q <= state_d;
  end

`ifdef MIRISCV_DATA_ARB_RR_EN
  always_comb begin
    state_d = state_q;
    if (state_q == PRIO0 && gnt_o[MASTER_CORE])     state_d = PRIO1;
    else if (state_q == PRIO1 && gnt_o[MASTER_EXT]) state_d = PRIO0;
  end
`else
  logic [7:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if (!req_i[MASTER_EXT] || gnt_o[MASTER_EXT]) starve_d = '0;
    else if (starve_q != 8'(STARVE_MAX))         starve_d = starve_q + 8'd1;
  end

  // Hand priority over as soon as the counter reaches the limit, so the
  // very next conflict goes to master 1.
  always_comb begin
    state_d = state_q;
    if (state_q == PRIO0 && starve_d == 8'(STARVE_MAX)) state_d = PRIO1;
    else if (state_q == PRIO1 && gnt_o[MASTER_EXT])     state_d = PRIO0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) starve_q <= '0;
    else          starve_q <= starve_d;
  end
`endif

endmodule

// File: rtl/miriscv_data_arb.sv
// Shares the miriscv_ram data port between two masters; decodes the RAM window
// and returns a registered response. Mode macro: MIRISCV_DATA_ARB_RR_EN.
module miriscv_data_arb
  import miriscv_pkg::*;
#(
  parameter int RAM_SIZE   = 256,
  parameter int STARVE_MAX = 8
) (
  input logic clk_i,
  input logic rst_n_i,
  miriscv_data_arb_if.slave bus
);

  localparam logic [DATA_W-1:0] RAM_LIMIT = DATA_W'(RAM_SIZE);

  logic [1:0]        req, gnt;
  logic              any_gnt, in_range;
  logic              sel_we;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_addr, sel_wdata;

  logic [1:0]        vld_p1;
  logic              err_p1;
  logic [DATA_W-1:0] rdata_p1;

  assign req = {bus.m1_req_i, bus.m0_req_i};

  miriscv_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .req_i   (req),
    .gnt_o   (gnt)
  );

  assign any_gnt = |gnt;

  // Master 0 drives the RAM mux whenever master 1 is not the winner.
  always_comb begin
    sel_we    = bus.m0_we_i;
    sel_be    = bus.m0_be_i;
    sel_addr  = bus.m0_addr_i;
    sel_wdata = bus.m0_wdata_i;
    if (gnt[MASTER_EXT]) begin
      sel_we    = bus.m1_we_i;
      sel_be    = bus.m1_be_i;
      sel_addr  = bus.m1_addr_i;
      sel_wdata = bus.m1_wdata_i;
    end
  end

  assign in_range = (sel_addr < RAM_LIMIT);

  assign bus.ram_req_o   = any_gnt & in_range;
  assign bus.ram_we_o    = rst_n_i & sel_we;
  assign bus.ram_be_o    = rst_n_i ? sel_be    : '0;
  assign bus.ram_addr_o  = rst_n_i ? sel_addr  : '0;
  assign bus.ram_wdata_o = rst_n_i ? sel_wdata : '0;

  // p0 -> p1: capture the grant cycle's outcome as the response.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_p1   <= '0;
      err_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1   <= gnt;
      err_p1   <= any_gnt & ~in_range;
      rdata_p1 <= (any_gnt && in_range && !sel_we) ? bus.ram_rdata_i : '0;
    end
  end

  assign bus.m0_gnt_o    = gnt[MASTER_CORE];
  assign bus.m0_rvalid_o = vld_p1[MASTER_CORE];
  assign bus.m0_err_o    = vld_p1[MASTER_CORE] & err_p1;
  assign bus.m0_rdata_o  = vld_p1[MASTER_CORE] ? rdata_p1 : '0;

  assign bus.m1_gnt_o    = gnt[MASTER_EXT];
  assign bus.m1_rvalid_o = vld_p1[MASTER_EXT];
  assign bus.m1_err_o    = vld_p1[MASTER_EXT] & err_p1;
  assign bus.m1_rdata_o  = vld_p1[MASTER_EXT] ? rdata_p1 : '0;

endmodule

// File: tb/tb_miriscv_data_arb.sv
// Directed bench for miriscv_data_arb; follows MIRISCV_DATA_ARB_RR_EN when set.
module tb_miriscv_data_arb;

  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b1;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   rv0_cnt = 0;
  int   rv1_cnt = 0;

  logic [31:0] mem [64];

  always #5 clk_i = ~clk_i;

  miriscv_data_arb_if bus_if ();

  miriscv_data_arb #(
    .RAM_SIZE   (256),
    .STARVE_MAX (8)
  ) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus_if)
  );

  // Behavioural RAM: combinational read, byte-enabled write on the clock edge.
  assign bus_if.ram_rdata_i = mem[bus_if.ram_addr_o[7:2]];

  always @(posedge clk_i) begin
    if (!rst_n_i) mem[4] <= 32'hDEADBEEF;
    else if (bus_if.ram_req_o && bus_if.ram_we_o)
      for (int b = 0; b < 4; b++)
        if (bus_if.ram_be_o[b])
          mem[bus_if.ram_addr_o[7:2]][8*b +: 8] <= bus_if.ram_wdata_o[8*b +: 8];
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_m0(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    bus_if.m0_req_i   = req;
    bus_if.m0_we_i    = we;
    bus_if.m0_be_i    = 4'hF;
    bus_if.m0_addr_i  = addr;
    bus_if.m0_wdata_i = wd;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    bus_if.m1_req_i   = req;
    bus_if.m1_we_i    = we;
    bus_if.m1_be_i    = 4'hF;
    bus_if.m1_addr_i  = addr;
    bus_if.m1_wdata_i = wd;
  endtask

  // Both masters read continuously; master 1 is expected to win on the last
  // cycle of every 'period'-cycle window.
  task automatic conflict(input int n, input int period);
    logic e1;
    set_m0(1'b1, 1'b0, 32'h10, 32'h0);
    set_m1(1'b1, 1'b0, 32'hFC, 32'h0);
    for (int i = 0; i < n; i++) begin
      e1 = ((i % period) == (period - 1));
      #1;
      chk1("conflict_gnt0", bus_if.m0_gnt_o, !e1);
      chk1("conflict_gnt1", bus_if.m1_gnt_o, e1);
      tick();
      chk1("conflict_rv0", bus_if.m0_rvalid_o, !e1);
      chk1("conflict_rv1", bus_if.m1_rvalid_o, e1);
      if (e1) chk32("conflict_rdata1", bus_if.m1_rdata_o, 32'h12345678);
      else    chk32("conflict_rdata0", bus_if.m0_rdata_o, 32'hDEADBEEF);
      if (bus_if.m0_rvalid_o) rv0_cnt++;
      if (bus_if.m1_rvalid_o) rv1_cnt++;
    end
  endtask

  initial begin
    set_m0(1'b0, 1'b0, 32'h0, 32'h0);
    set_m1(1'b0, 1'b0, 32'h0, 32'h0);
    #2 rst_n_i = 1'b0;
    set_m0(1'b1, 1'b1, 32'h10, 32'hA5A5A5A5);
    tick();
    tick();
    chk1 ("rst_gnt0", bus_if.m0_gnt_o, 1'b0);
    chk1 ("rst_ram_req", bus_if.ram_req_o, 1'b0);
    chk1 ("rst_ram_we", bus_if.ram_we_o, 1'b0);
    chk32("rst_ram_addr", bus_if.ram_addr_o, 32'h0);
    chk32("rst_ram_wdata", bus_if.ram_wdata_o, 32'h0);
    chk1 ("rst_rv0", bus_if.m0_rvalid_o, 1'b0);
    chk32("rst_rdata0", bus_if.m0_rdata_o, 32'h0);
    set_m0(1'b0, 1'b0, 32'h0, 32'h0);
    rst_n_i = 1'b1;
    tick();
    chk1("idle_rv0", bus_if.m0_rvalid_o, 1'b0);
    chk1("idle_rv1", bus_if.m1_rvalid_o, 1'b0);

    // m0 alone reads 0x10
    set_m0(1'b1, 1'b0, 32'h10, 32'h0);
    #1;
    chk1 ("rd_gnt0", bus_if.m0_gnt_o, 1'b1);
    chk1 ("rd_gnt1", bus_if.m1_gnt_o, 1'b0);
    chk1 ("rd_ram_req", bus_if.ram_req_o, 1'b1);
    chk32("rd_ram_addr", bus_if.ram_addr_o, 32'h10);
    tick();
    chk1 ("rd_rv0", bus_if.m0_rvalid_o, 1'b1);
    chk32("rd_rdata0", bus_if.m0_rdata_o, 32'hDEADBEEF);
    chk1 ("rd_err0", bus_if.m0_err_o, 1'b0);
    chk1 ("rd_rv1", bus_if.m1_rvalid_o, 1'b0);
    set_m0(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk1("rd_pulse", bus_if.m0_rvalid_o, 1'b0);

    // m1 writes 0xFC then reads it back, back to back
    set_m1(1'b1, 1'b1, 32'hFC, 32'h12345678);
    #1;
    chk1 ("wr_gnt1", bus_if.m1_gnt_o, 1'b1);
    chk1 ("wr_ram_req", bus_if.ram_req_o, 1'b1);
    chk1 ("wr_ram_we", bus_if.ram_we_o, 1'b1);
    chk32("wr_ram_addr", bus_if.ram_addr_o, 32'hFC);
    chk32("wr_ram_wdata", bus_if.ram_wdata_o, 32'h12345678);
    tick();
    chk1 ("wr_rv1", bus_if.m1_rvalid_o, 1'b1);
    chk32("wr_rdata1", bus_if.m1_rdata_o, 32'h0);
    chk1 ("wr_err1", bus_if.m1_err_o, 1'b0);
    set_m1(1'b1, 1'b0, 32'hFC, 32'h0);
    #1;
    chk1("rb_ram_we", bus_if.ram_we_o, 1'b0);
    chk1("rb_ram_req", bus_if.ram_req_o, 1'b1);
    tick();
    chk1 ("rb_rv1", bus_if.m1_rvalid_o, 1'b1);
    chk32("rb_rdata1", bus_if.m1_rdata_o, 32'h12345678);
    set_m1(1'b0, 1'b0, 32'h0, 32'h0);

    // Address window boundary: 0xFF, 0x100, 0xFFFFFFFC
    set_m0(1'b1, 1'b0, 32'hFF, 32'h0);
    #1;
    chk1("b_ff_ram_req", bus_if.ram_req_o, 1'b1);
    tick();
    chk1 ("b_ff_err", bus_if.m0_err_o, 1'b0);
    chk32("b_ff_rdata", bus_if.m0_rdata_o, 32'h12345678);
    set_m0(1'b1, 1'b0, 32'h100, 32'h0);
    #1;
    chk1("b_100_gnt", bus_if.m0_gnt_o, 1'b1);
    chk1("b_100_ram_req", bus_if.ram_req_o, 1'b0);
    tick();
    chk1 ("b_100_rv", bus_if.m0_rvalid_o, 1'b1);
    chk1 ("b_100_err", bus_if.m0_err_o, 1'b1);
    chk32("b_100_rdata", bus_if.m0_rdata_o, 32'h0);
    set_m0(1'b1, 1'b0, 32'hFFFFFFFC, 32'h0);
    #1;
    chk1("b_top_gnt", bus_if.m0_gnt_o, 1'b1);
    chk1("b_top_ram_req", bus_if.ram_req_o, 1'b0);
    tick();
    chk1 ("b_top_err", bus_if.m0_err_o, 1'b1);
    chk32("b_top_rdata", bus_if.m0_rdata_o, 32'h0);
    set_m0(1'b0, 1'b0, 32'h0, 32'h0);

    // m1 alone reads 0x10 (also returns round-robin priority to m0)
    set_m1(1'b1, 1'b0, 32'h10, 32'h0);
    #1;
    chk1("m1rd_gnt1", bus_if.m1_gnt_o, 1'b1);
    tick();
    chk32("m1rd_rdata1", bus_if.m1_rdata_o, 32'hDEADBEEF);
    chk1 ("m1rd_rv0", bus_if.m0_rvalid_o, 1'b0);
    set_m1(1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    rv0_cnt = 0;
    rv1_cnt = 0;
`ifdef MIRISCV_DATA_ARB_RR_EN
    conflict(6, 2);
    chk32("rr_rv0_count", 32'(rv0_cnt), 32'd3);
    chk32("rr_rv1_count", 32'(rv1_cnt), 32'd3);
    set_m1(1'b0, 1'b0, 32'h0, 32'h0);
    set_m0(1'b1, 1'b0, 32'h10, 32'h0);
    #1;
    chk1("pre_rst_gnt0", bus_if.m0_gnt_o, 1'b1);
`else
    conflict(18, 9);
    chk32("fp_rv0_count", 32'(rv0_cnt), 32'd16);
    chk32("fp_rv1_count", 32'(rv1_cnt), 32'd2);
    // Dropping m1's request must clear the starvation count.
    conflict(5, 9);
    set_m1(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk1("drop_gnt0", bus_if.m0_gnt_o, 1'b1);
    tick();
    conflict(9, 9);
    conflict(7, 9);
    #1;
    chk1("pre_rst_gnt0", bus_if.m0_gnt_o, 1'b1);
    chk1("pre_rst_gnt1", bus_if.m1_gnt_o, 1'b0);
`endif

    // Reset in the cycle after a grant, with both masters requesting
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b0;
    set_m0(1'b1, 1'b1, 32'h10, 32'h55AA55AA);
    set_m1(1'b1, 1'b0, 32'hFC, 32'h0);
    #1;
    chk1 ("mid_rst_rv0", bus_if.m0_rvalid_o, 1'b0);
    chk32("mid_rst_rdata0", bus_if.m0_rdata_o, 32'h0);
    chk1 ("mid_rst_gnt0", bus_if.m0_gnt_o, 1'b0);
    chk1 ("mid_rst_gnt1", bus_if.m1_gnt_o, 1'b0);
    chk1 ("mid_rst_ram_req", bus_if.ram_req_o, 1'b0);
    chk1 ("mid_rst_ram_we", bus_if.ram_we_o, 1'b0);
    chk32("mid_rst_ram_be", 32'(bus_if.ram_be_o), 32'h0);
    chk32("mid_rst_ram_addr", bus_if.ram_addr_o, 32'h0);
    tick();
    set_m0(1'b0, 1'b0, 32'h0, 32'h0);
    set_m1(1'b0, 1'b0, 32'h0, 32'h0);
    rst_n_i = 1'b1;
    tick();
    chk1("post_rst_rv0", bus_if.m0_rvalid_o, 1'b0);
    chk1("post_rst_rv1", bus_if.m1_rvalid_o, 1'b0);
`ifdef MIRISCV_DATA_ARB_RR_EN
    conflict(2, 2);
`else
    conflict(9, 9);
`endif
    set_m0(1'b0, 1'b0, 32'h0, 32'h0);
    set_m1(1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
